booth_seq_multiplier: RTL and testbench

Iterative radix-2 Booth signed multiplier: one FSM sequences a single add/subtract/shift datapath over N clock cycles instead of N parallel stages. Used where area matters more than latency, behind a start/busy/done handshake. Arithmetic results are bit-identical to the team's combinational Booth multiplier for the same N, so either can be swapped in.

---
 rtl/booth_seq_multiplier_pkg.sv | 28 ++
 rtl/booth_seq_multiplier_if.sv | 24 ++
 rtl/booth_seq_multiplier_step.sv | 41 ++++
 rtl/booth_seq_multiplier.sv | 109 ++++++++++
 tb/tb_booth_seq_multiplier.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/booth_seq_multiplier_pkg.sv
// Shared definitions for the sequential Booth multiplier.
// Covers state codes, Booth recoding ops and the iteration-counter width helper.
package booth_seq_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        OP_NOP = 2'd0,
        OP_ADD = 2'd1,
        OP_SUB = 2'd2
    } booth_op_e;

    // The counter has to hold N itself, hence n+1.
    function automatic int count_width(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic booth_op_e booth_decode(input logic q0, input logic q_m1);
        case ({q0, q_m1})
            2'b01:   return OP_ADD;
            2'b10:   return OP_SUB;
            default: return OP_NOP;
        endcase
    endfunction

endpackage

// File: rtl/booth_seq_multiplier_if.sv
// start/busy/done handshake bundle for booth_seq_multiplier.
// The master drives the request and operands; the slave returns status and product.
interface booth_seq_multiplier_if #(
    parameter int N = 4
) ();
    localparam int WIDTH = 2 * N;

    logic             start;
    logic [N-1:0]     multiplicand;
    logic [N-1:0]     multiplier;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] product;

    modport master (
        output start, multiplicand, multiplier,
        input  busy, done, product
    );

    modport slave (
        input  start, multiplicand, multiplier,
        output busy, done, product
    );
endinterface

// File: rtl/booth_seq_multiplier_step.sv
// One radix-2 Booth iteration: conditional add/subtract of M into acc,
// followed by an arithmetic right shift of {acc, Q, q_m1}.
module booth_step
    import booth_seq_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N:0]   acc_i,
    input  logic [N-1:0] q_i,
    input  logic         q_m1_i,
    input  logic [N:0]   m_i,
    output logic [N:0]   acc_o,
    output logic [N-1:0] q_o,
    output logic         q_m1_o
);
    booth_op_e    op;
    logic [N:0]   sum;

    assign op = booth_decode(q_i[0], q_m1_i);

    always_comb begin
        sum = acc_i;
        case (op)
            OP_ADD:  sum = acc_i + m_i;
            OP_SUB:  sum = acc_i - m_i;
            default: sum = acc_i;
        endcase
    end

    // acc keeps its sign bit; its LSB falls into the top of Q.
    assign acc_o    = {sum[N], sum[N:1]};
    assign q_o[N-1] = sum[0];
    assign q_m1_o   = q_i[0];

    generate
        for (genvar gi = 0; gi < N - 1; gi++) begin : g_q_shift
            assign q_o[gi] = q_i[gi + 1];
        end
    endgenerate

endmodule

// File: rtl/booth_seq_multiplier.sv
// Iterative radix-2 Booth signed multiplier: N add/shift steps on one datapath,
// sequenced by an IDLE/RUN/DONE FSM behind a start/busy/done handshake.
module booth_seq_multiplier
    import booth_seq_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    booth_seq_multiplier_if.slave  bus
);
    localparam int WIDTH = 2 * N;
    localparam int CW    = count_width(N);

    logic [1:0]       state_q,   state_d;
    logic [N:0]       acc_q,     acc_d;
    logic [N:0]       m_q,       m_d;
    logic [N-1:0]     q_q,       q_d;
    logic             q_m1_q,    q_m1_d;
    logic [CW-1:0]    count_q,   count_d;
    logic [WIDTH-1:0] product_q, product_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;

    logic [N:0]       acc_step;
    logic [N-1:0]     q_step;
    logic             q_m1_step;

    booth_step #(
        .N (N)
    ) u_step (
        .acc_i  (acc_q),
        .q_i    (q_q),
        .q_m1_i (q_m1_q),
        .m_i    (m_q),
        .acc_o  (acc_step),
        .q_o    (q_step),
        .q_m1_o (q_m1_step)
    );

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        m_d       = m_q;
        q_d       = q_q;
        q_m1_d    = q_m1_q;
        count_d   = count_q;
        product_d = product_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    // N+1-bit M lets -2^(N-1) be negated without overflow.
                    m_d     = {bus.multiplicand[N-1], bus.multiplicand};
                    q_d     = bus.multiplier;
                    q_m1_d  = 1'b0;
                    acc_d   = '0;
                    count_d = CW'(N);
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                acc_d   = acc_step;
                q_d     = q_step;
                q_m1_d  = q_m1_step;
                count_d = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    product_d = {acc_step[N-1:0], q_step};
                    state_d   = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            acc_q     <= '0;
            m_q       <= '0;
            q_q       <= '0;
            q_m1_q    <= 1'b0;
            count_q   <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            m_q       <= m_d;
            q_q       <= q_d;
            q_m1_q    <= q_m1_d;
            count_q   <= count_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.product = product_q;

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Self-checking bench for booth_seq_multiplier (N=4): scoreboard of expected
// products pushed at start, popped and compared on each done pulse.
module tb_booth_seq_multiplier;
    localparam int N     = 4;
    localparam int WIDTH = 2 * N;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    booth_seq_multiplier_if #(.N(N)) bus ();

    booth_seq_multiplier #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic signed [WIDTH-1:0] exp_q[$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic drive_start(input int a, input int b, input int expected);
        bus.multiplicand = N'(a);
        bus.multiplier   = N'(b);
        bus.start        = 1'b1;
        exp_q.push_back(WIDTH'(expected));
    endtask

    task automatic check_pop(input string name);
        logic signed [WIDTH-1:0] e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: done with product=%0d but scoreboard empty", name, $signed(bus.product));
        end else begin
            e = exp_q.pop_front();
            if (bus.product !== e) begin
                n_fail++;
                $display("FAIL %s: product=%0d expected=%0d", name, $signed(bus.product), e);
            end else begin
                $display("txn %s: product=%0d", name, $signed(bus.product));
            end
        end
    endtask

    // Called just after the accepting edge; expects done at the (N+1)th negedge.
    task automatic wait_done(input string name);
        bit seen = 0;
        for (int c = 1; c <= N + 4; c++) begin
            @(negedge clk);
            if (bus.done) begin
                seen = 1;
                n_checks++;
                if (c != N + 1) begin
                    n_fail++;
                    $display("FAIL %s_latency: done at cycle %0d expected %0d", name, c, N + 1);
                end
                check_pop(name);
                break;
            end
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: no done within %0d cycles expected 1 pulse", name, N + 4);
        end
    endtask

    task automatic run_one(input int a, input int b, input int expected, input string name);
        @(posedge clk); #1;
        drive_start(a, b, expected);
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done(name);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if ({bus.busy, bus.done, bus.product} !== '0) begin
                n_fail++;
                $display("FAIL reset_idle: busy=%b done=%b product=%0d expected 0/0/0",
                         bus.busy, bus.done, bus.product);
            end
        end
    endtask

    task automatic test_basic();
        logic exp_b;
        @(posedge clk); #1;
        drive_start(2, 3, 6);
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int c = 1; c <= N + 2; c++) begin
            @(negedge clk);
            exp_b = (c <= N);
            n_checks++;
            if (bus.busy !== exp_b) begin
                n_fail++;
                $display("FAIL basic_busy: cycle %0d busy=%b expected %b", c, bus.busy, exp_b);
            end
            exp_b = (c == N + 1);
            n_checks++;
            if (bus.done !== exp_b) begin
                n_fail++;
                $display("FAIL basic_done: cycle %0d done=%b expected %b", c, bus.done, exp_b);
            end
            if (bus.done) check_pop("basic_2x3");
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.product !== WIDTH'(6)) begin
            n_fail++;
            $display("FAIL basic_hold: product=%0d expected 6", $signed(bus.product));
        end
    endtask

    task automatic test_sequence();
        int ma[6] = '{-2, -5, 7, 7, -8, 4};
        int mb[6] = '{3, -6, -1, -8, -8, 0};
        int pe[6] = '{-6, 30, -7, -56, 64, 0};
        for (int i = 0; i < 6; i++)
            run_one(ma[i], mb[i], pe[i], $sformatf("seq_%0dx%0d", ma[i], mb[i]));
    endtask

    task automatic test_busy_ignore();
        int n_done = 0;
        @(posedge clk); #1;
        drive_start(2, 3, 6);
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        bus.multiplicand = N'(5);
        bus.multiplier   = N'(5);
        bus.start        = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.done) begin
                n_done++;
                check_pop("ignore_2x3");
            end
        end
        n_checks++;
        if (n_done != 1) begin
            n_fail++;
            $display("FAIL ignore_pulses: done pulses=%0d expected 1", n_done);
        end
    endtask

    task automatic test_back_to_back();
        int n_done = 0;
        int last = 0;
        logic exp_b;
        @(posedge clk); #1;
        drive_start(3, 3, 9);
        @(posedge clk); #1;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (bus.done) begin
                n_done++;
                n_checks++;
                if (bus.busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_busy_done: cycle %0d busy=%b expected 0", c, bus.busy);
                end
                n_checks++;
                if (c - last != N + 1) begin
                    n_fail++;
                    $display("FAIL b2b_interval: done interval %0d expected %0d", c - last, N + 1);
                end
                check_pop($sformatf("b2b_%0d", n_done));
                last = c;
                if (n_done == 1) begin
                    bus.multiplicand = N'(-4);
                    bus.multiplier   = N'(5);
                    exp_q.push_back(WIDTH'(-20));
                end else begin
                    bus.start = 1'b0;
                end
            end else begin
                exp_b = (n_done < 2);
                n_checks++;
                if (bus.busy !== exp_b) begin
                    n_fail++;
                    $display("FAIL b2b_busy: cycle %0d busy=%b expected %b", c, bus.busy, exp_b);
                end
            end
        end
        bus.start = 1'b0;
        n_checks++;
        if (n_done != 2) begin
            n_fail++;
            $display("FAIL b2b_pulses: done pulses=%0d expected 2", n_done);
        end
    endtask

    task automatic test_reset_mid();
        int n_done = 0;
        // The aborted operation never completes, so nothing goes on the scoreboard.
        @(posedge clk); #1;
        bus.multiplicand = N'(-5);
        bus.multiplier   = N'(-6);
        bus.start        = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus.busy, bus.done, bus.product} !== '0 || dut.state_q !== 2'd0) begin
            n_fail++;
            $display("FAIL midreset_state: busy=%b done=%b product=%0d state=%0d expected 0/0/0/0",
                     bus.busy, bus.done, bus.product, dut.state_q);
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.done) n_done++;
        end
        n_checks++;
        if (n_done != 0) begin
            n_fail++;
            $display("FAIL midreset_nodone: done pulses=%0d expected 0", n_done);
        end
        run_one(3, -3, -9, "midreset_3x-3");
    endtask

    task automatic test_exhaustive();
        for (int a = -8; a <= 7; a++)
            for (int b = -8; b <= 7; b++)
                run_one(a, b, a * b, $sformatf("sweep_%0dx%0d", a, b));
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sequence();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        test_exhaustive();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
